// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: pulses bit_done on the last rd_clk cycle of each serial bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic rd_clk,
  input  logic reset_n,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_done = (cnt_q == LAST);

  // Restart from zero at the terminal count so the counter never wraps past it.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || bit_done) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the read side of the byte FIFO and sends them as 8N1 UART frames.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       rd_clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy
);

  tx_state_e   state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        bit_done;
`ifdef FIFO_UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  // Counter is held at zero in IDLE so every frame starts with a full-length start bit.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .rd_clk  (rd_clk),
    .reset_n (reset_n),
    .clear   (state_q == IDLE),
    .bit_done(bit_done)
  );

  assign tx   = tx_q;
  assign busy = busy_q;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    fifo_rd   = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        fifo_rd = enable && !fifo_empty;
        if (fifo_rd) begin
          shreg_d   = fifo_data;
          bit_idx_d = 3'd0;
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_d  = ^fifo_data;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            bit_idx_d = 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_d   = PARITY;
            tx_d      = parity_q;
`else
            state_d   = STOP;
            tx_d      = IDLE_LEVEL;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shreg_d[0];
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          tx_d    = IDLE_LEVEL;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          tx_d    = IDLE_LEVEL;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the 8x8 byte FIFO, clocked in the FIFO read-clock domain.
- Pops one byte whenever the FIFO is not empty and transmission is enabled.
- Serializes each byte onto a UART line as 8N1 (start bit, 8 data bits LSB first, stop bit), with a fixed clock divider.
- Feeds the board-level serial TX pin.

Parameters:
- CLKS_PER_BIT, 16: rd_clk cycles per serial bit. Legal range 2..65535.

Ports:
- rd_clk  input  1  FIFO read clock; the only clock of this block.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  permits starting a new frame; sampled only in IDLE.
- fifo_empty  input  1  empty flag from the FIFO.
- fifo_data  input  8  FIFO head byte (combinational data_out of the FIFO).
- fifo_rd  output  1  FIFO read strobe; one-cycle pop.
- tx  output  1  serial line; idle high; registered.
- busy  output  1  high while a frame is in progress (state != IDLE); registered.

Behaviour:
- Single clock rd_clk, reset is asynchronous active-low (reset_n); all flops clear on negedge reset_n.
- Reset values:
  - tx=1, busy=0, fifo_rd=0.
  - state=IDLE; baud counter=0, bit index=0, shift register=0.
- States: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
- IDLE:
  - fifo_rd = enable && !fifo_empty, combinational from state and inputs. It is glitch-free because all inputs are rd_clk-synchronous.
  - On an edge where fifo_rd=1: shift register <= fifo_data, state <= START, tx <= 0, busy <= 1, baud counter <= 0.
  - The FIFO advances rd_addr on the same edge, so the byte is consumed exactly once.
- START: tx=0 for CLKS_PER_BIT cycles. When baud counter reaches CLKS_PER_BIT-1: counter <= 0, state <= DATA, tx <= shreg[0].
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles.
  - At each bit end, the shift register shifts right and the bit index increments; the next tx is the new shreg[0].
  - After bit index 7 completes: state <= STOP, tx <= 1.
- STOP: tx=1 for CLKS_PER_BIT cycles, then state <= IDLE, busy <= 0.
- Frame timing:
  - Every frame spends at least one cycle in IDLE before the next pop.
  - Back-to-back frame period = 10*CLKS_PER_BIT + 1 cycles.
- fifo_rd is never asserted outside IDLE, and never when fifo_empty=1.
  - A pop on empty is impossible by construction; the bench asserts it anyway.
- enable deasserted mid-frame: the current frame completes normally; no new pop follows.
- fifo_empty changing mid-frame: no effect until IDLE.
- Reset mid-frame: tx returns high immediately (async). The in-flight byte is lost; it was already popped. The FSM restarts in IDLE.
- Widths:
  - Baud counter is $clog2(CLKS_PER_BIT) bits, compared against CLKS_PER_BIT-1, with no wrap past the terminal value.
  - Bit index is 3 bits.

Optional Feature:
- Macro FIFO_UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP; tx = even parity (XOR of the 8 data bits captured at pop) for CLKS_PER_BIT cycles.
  - Frame is 11 bits; back-to-back period = 11*CLKS_PER_BIT + 1.
- Undefined: no PARITY state or parity logic; 8N1 only.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] tx_state_e {IDLE, START, DATA, PARITY, STOP};
  - localparam DATA_BITS = 8; localparam IDLE_LEVEL = 1'b1.
- Sub-module uart_baud_gen: the baud counter.
  - Inputs: rd_clk, reset_n, clear.
  - Output: bit_done pulse when count == CLKS_PER_BIT-1.
  - Instantiated once.

Test Plan (CLKS_PER_BIT=4 unless stated):
- Reset with enable=1, fifo_empty=1 -> tx=1, busy=0, fifo_rd never asserted over 100 cycles.
- Single byte 8'hA5, fifo_empty low one pop then high -> fifo_rd high exactly 1 cycle; tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy high for 40 cycles.
- Three bytes 8'h00, 8'hFF, 8'h3C preloaded, enable=1 -> three pops spaced 41 cycles apart; frames decode in order; no extra pop after the FIFO goes empty.
- enable dropped at cycle 10 of the 8'h55 frame -> frame completes intact; no further pop while enable=0; popping resumes 1 cycle after enable returns.
- reset_n pulsed low at cycle 17 of a frame -> tx=1 asynchronously, busy=0; the next frame starts with a clean start bit of 4 cycles.
- FIFO_UART_TX_PARITY_EN defined, byte 8'h07 -> parity bit 1 after data; frame is 44 cycles; 8'h03 gives parity bit 0.
